// File: rtl/icache_direct_mapped_pkg.sv
// Shared types, geometry and field helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned NUM_BLOCKS  = 8;
  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned ADDR_W      = 10;

  localparam int unsigned INDEX_W    = $clog2(NUM_BLOCKS);
  localparam int unsigned OFFSET_W   = $clog2(BLOCK_BYTES);
  localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned WORD_W     = OFFSET_W - 2;
  localparam int unsigned DATA_W     = BLOCK_BYTES * 8;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned MEM_ADDR_W = TAG_W + INDEX_W;

  // Field positions inside the CPU byte address
  localparam int unsigned TAG_LSB   = 7;
  localparam int unsigned INDEX_LSB = 4;
  localparam int unsigned WORD_LSB  = 2;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMemRead = 2'd1,
    StUpdate  = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[TAG_LSB +: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_LSB +: INDEX_W];
  endfunction

  function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[WORD_LSB +: WORD_W];
  endfunction

  // Little-endian word pick: word 0 lives in bits [31:0]
  function automatic logic [INSTR_W-1:0] word_select(input logic [DATA_W-1:0] data,
                                                     input logic [WORD_W-1:0] word);
    logic [6:0] lsb;
    lsb = {word, 5'd0};
    return data[lsb +: INSTR_W];
  endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// CPU fetch port and instruction-memory refill port of the cache.
interface icache_direct_mapped_if
  import icache_pkg::*;
();

  logic [ADDR_W-1:0]     address;
  logic [INSTR_W-1:0]    instruction;
  logic                  busywait;
  logic                  mem_read;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0]     mem_readdata;
  logic                  mem_busywait;

  // Cache side
  modport slave (
    input  address,
    input  mem_readdata,
    input  mem_busywait,
    output instruction,
    output busywait,
    output mem_read,
    output mem_address
  );

  // CPU + memory side
  modport master (
    output address,
    output mem_readdata,
    output mem_busywait,
    input  instruction,
    input  busywait,
    input  mem_read,
    input  mem_address
  );

endinterface

// File: rtl/icache_direct_mapped_line_array.sv
// Valid/tag/data storage: async-clearable valid bits, one write port, one comb read port.
module icache_line_array
  import icache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] waddr_i,
  input  logic [TAG_W-1:0]   wtag_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [INDEX_W-1:0] raddr_i,
  output line_t              rline_o
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [DATA_W-1:0]     data_q [NUM_BLOCKS];

  // Valid bits are the only state cleared by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[waddr_i] <= 1'b1;
    end
  end

  // Tag and data arrays keep their contents across reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[waddr_i]  <= wtag_i;
      data_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read of the addressed line
  always_comb begin
    rline_o.valid = valid_q[raddr_i];
    rline_o.tag   = tag_q[raddr_i];
    rline_o.data  = data_q[raddr_i];
  end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: same-cycle hits, blocking single-block refill.
module icache_direct_mapped
  import icache_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  icache_direct_mapped_if.slave  bus
);

  logic [TAG_W-1:0]   cur_tag;
  logic [INDEX_W-1:0] cur_index;
  logic [WORD_W-1:0]  cur_word;
  logic               unused_addr_bits;

  line_t              rline;
  logic               hit;
  logic [INSTR_W-1:0] hit_word;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   miss_tag_q;
  logic [INDEX_W-1:0] miss_index_q;
  logic [DATA_W-1:0]  fill_data_q;
  logic [INSTR_W-1:0] last_instr_q;

  logic               busy_raw;
  logic               line_we;

  assign cur_tag          = addr_tag(bus.address);
  assign cur_index        = addr_index(bus.address);
  assign cur_word         = addr_word(bus.address);
  assign unused_addr_bits = ^bus.address[WORD_LSB-1:0];

  icache_line_array u_lines (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .we_i    (line_we),
    .waddr_i (miss_index_q),
    .wtag_i  (miss_tag_q),
    .wdata_i (fill_data_q),
    .raddr_i (cur_index),
    .rline_o (rline)
  );

  assign hit      = rline.valid && (rline.tag == cur_tag);
  assign hit_word = word_select(rline.data, cur_word);

  // On a miss the CPU sees the last word it successfully fetched
  assign bus.instruction = hit ? hit_word : last_instr_q;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (!hit) state_d = StMemRead;
      StMemRead: if (!bus.mem_busywait) state_d = StUpdate;
      StUpdate:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs: refill request, stall and line write strobe
  always_comb begin
    busy_raw        = 1'b0;
    bus.mem_read    = 1'b0;
    line_we         = 1'b0;
    bus.mem_address = {miss_tag_q, miss_index_q};
    unique case (state_q)
      StIdle:    busy_raw = !hit;
      StMemRead: begin
        busy_raw     = 1'b1;
        bus.mem_read = 1'b1;
      end
      StUpdate:  begin
        busy_raw = 1'b1;
        line_we  = 1'b1;
      end
      default:   busy_raw = 1'b0;
    endcase
    // Stall is suppressed while reset is held even though every line reads invalid
    bus.busywait = RESET && busy_raw;
  end

  // Latch the refill target so address glitches during a stall cannot redirect it
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      miss_tag_q   <= '0;
      miss_index_q <= '0;
    end else if (state_q == StIdle && !hit) begin
      miss_tag_q   <= cur_tag;
      miss_index_q <= cur_index;
    end
  end

  // Capture the returned block on the edge the memory finishes
  always_ff @(posedge CLK) begin
    if (state_q == StMemRead && !bus.mem_busywait) begin
      fill_data_q <= bus.mem_readdata;
    end
  end

  // Remember the most recent hit word for display during a miss
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_instr_q <= '0;
    end else if (state_q == StIdle && hit) begin
      last_instr_q <= hit_word;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped with a variable-latency memory model.
module tb_icache_direct_mapped;
  import icache_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_direct_mapped_if bus ();

  icache_direct_mapped dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  // Instruction memory: 64 blocks of 128 bits, latency of lat cycles per request
  logic [127:0] mem_blk [64];
  int           lat     = 5;
  int           mem_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            mem_cnt <= 0;
    else if (bus.mem_read) mem_cnt <= mem_cnt + 1;
    else                   mem_cnt <= 0;
  end

  assign bus.mem_busywait = !(bus.mem_read && (mem_cnt >= lat - 1));
  assign bus.mem_readdata = mem_blk[bus.mem_address];

  // Record the block address of every mem_read burst
  logic       mem_read_prev = 1'b0;
  logic [5:0] seen_q [$];
  always @(negedge clk) begin
    if (bus.mem_read && !mem_read_prev) seen_q.push_back(bus.mem_address);
    mem_read_prev <= bus.mem_read;
  end

  int checks = 0;
  int passed = 0;

  // Scoreboard queues
  logic [31:0] exp_instr_q [$];
  int          exp_stall_q [$];
  logic [5:0]  exp_blk_q   [$];

  function automatic logic [31:0] exp_word(input logic [9:0] a);
    logic [127:0] blk;
    blk = mem_blk[a[9:4]];
    return blk[{a[3:2], 5'd0} +: 32];
  endfunction

  task automatic do_fetch(input logic [9:0] a, input bit release_rst,
                          output logic [31:0] ins, output int stalls);
    @(posedge clk);
    #1;
    bus.address = a;
    if (release_rst) rst_n = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (bus.busywait && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    ins = bus.instruction;
  endtask

  task automatic test_reset();
    logic [31:0] ins;
    rst_n       = 1'b0;
    bus.address = 10'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busywait !== 1'b0)
      $display("FAIL reset_busywait: got %b want 0", bus.busywait);
    else passed++;
    checks++;
    if (bus.mem_read !== 1'b0)
      $display("FAIL reset_mem_read: got %b want 0", bus.mem_read);
    else passed++;
    ins = bus.instruction;
    checks++;
    if (ins !== 32'h0)
      $display("FAIL reset_instruction: got %h want 00000000", ins);
    else passed++;
  endtask

  task automatic test_cold_start();
    logic [31:0] ins, e_ins;
    int          stalls, e_st;
    logic [5:0]  e_blk, s_blk;
    lat = 5;
    seen_q.delete();
    exp_instr_q.push_back(32'h00000009);
    exp_stall_q.push_back(7);
    exp_blk_q.push_back(6'd0);
    do_fetch(10'h000, 1'b1, ins, stalls);
    e_st = exp_stall_q.pop_front();
    checks++;
    if (stalls !== e_st) $display("FAIL cold_stall: got %0d want %0d", stalls, e_st);
    else passed++;
    e_ins = exp_instr_q.pop_front();
    checks++;
    if (ins !== e_ins) $display("FAIL cold_instr: got %h want %h", ins, e_ins);
    else passed++;
    while (exp_blk_q.size() > 0) begin
      e_blk = exp_blk_q.pop_front();
      checks++;
      if (seen_q.size() == 0) $display("FAIL cold_burst: got none want %0d", e_blk);
      else begin
        s_blk = seen_q.pop_front();
        if (s_blk !== e_blk) $display("FAIL cold_burst: got %0d want %0d", s_blk, e_blk);
        else passed++;
      end
    end
  endtask

  task automatic test_spatial_hits();
    logic [31:0] words [3];
    logic [31:0] ins, e_ins;
    int          stalls;
    words[0] = 32'h00010001;
    words[1] = 32'h0A000001;
    words[2] = 32'h0B000100;
    seen_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_instr_q.push_back(words[i]);
      do_fetch(10'((i + 1) * 4), 1'b0, ins, stalls);
      e_ins = exp_instr_q.pop_front();
      checks++;
      if (stalls !== 0) $display("FAIL spatial_stall[%0d]: got %0d want 0", i, stalls);
      else passed++;
      checks++;
      if (ins !== e_ins) $display("FAIL spatial_instr[%0d]: got %h want %h", i, ins, e_ins);
      else passed++;
    end
    checks++;
    if (seen_q.size() != 0)
      $display("FAIL spatial_no_mem_read: got %0d bursts want 0", seen_q.size());
    else passed++;
  endtask

  task automatic test_conflict();
    logic [9:0]  addrs [3];
    logic [31:0] ins, e_ins;
    int          stalls, e_st;
    logic [5:0]  e_blk, s_blk;
    addrs[0] = 10'h010;
    addrs[1] = 10'h090;
    addrs[2] = 10'h010;
    lat = 3;
    seen_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_instr_q.push_back(exp_word(addrs[i]));
      exp_stall_q.push_back(lat + 2);
      exp_blk_q.push_back(addrs[i][9:4]);
      do_fetch(addrs[i], 1'b0, ins, stalls);
      e_st  = exp_stall_q.pop_front();
      e_ins = exp_instr_q.pop_front();
      checks++;
      if (stalls !== e_st) $display("FAIL conflict_stall[%0d]: got %0d want %0d", i, stalls, e_st);
      else passed++;
      checks++;
      if (ins !== e_ins) $display("FAIL conflict_instr[%0d]: got %h want %h", i, ins, e_ins);
      else passed++;
    end
    checks++;
    if (seen_q.size() != 3) $display("FAIL conflict_bursts: got %0d want 3", seen_q.size());
    else passed++;
    while (exp_blk_q.size() > 0) begin
      e_blk = exp_blk_q.pop_front();
      checks++;
      if (seen_q.size() == 0) $display("FAIL conflict_addr: got none want %0d", e_blk);
      else begin
        s_blk = seen_q.pop_front();
        if (s_blk !== e_blk) $display("FAIL conflict_addr: got %0d want %0d", s_blk, e_blk);
        else passed++;
      end
    end
  endtask

  task automatic test_top_of_memory();
    logic [31:0] ins, e_ins;
    int          stalls, e_st;
    logic [5:0]  s_blk;
    lat = 1;
    seen_q.delete();
    exp_instr_q.push_back(32'hDEADBEEF);
    exp_stall_q.push_back(3);
    do_fetch(10'h3FC, 1'b0, ins, stalls);
    e_st  = exp_stall_q.pop_front();
    e_ins = exp_instr_q.pop_front();
    checks++;
    if (stalls !== e_st) $display("FAIL top_stall: got %0d want %0d", stalls, e_st);
    else passed++;
    checks++;
    if (ins !== e_ins) $display("FAIL top_instr: got %h want %h", ins, e_ins);
    else passed++;
    checks++;
    s_blk = (seen_q.size() > 0) ? seen_q.pop_front() : 6'd0;
    if (s_blk !== 6'd63) $display("FAIL top_mem_address: got %0d want 63", s_blk);
    else passed++;
  endtask

  task automatic test_reset_mid_refill();
    logic [9:0]  a;
    logic [31:0] ins, e_ins;
    int          stalls;
    logic [5:0]  s_blk;
    a   = 10'h044;
    lat = 5;
    @(posedge clk);
    #1 bus.address = a;
    @(posedge clk);  // enters MEM_READ
    @(posedge clk);  // second MEM_READ cycle
    #1;
    checks++;
    if (bus.mem_read !== 1'b1) $display("FAIL midrst_pre_mem_read: got %b want 1", bus.mem_read);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0) $display("FAIL midrst_mem_read: got %b want 0", bus.mem_read);
    else passed++;
    checks++;
    if (bus.busywait !== 1'b0) $display("FAIL midrst_busywait: got %b want 0", bus.busywait);
    else passed++;
    repeat (2) @(posedge clk);
    seen_q.delete();
    exp_instr_q.push_back(exp_word(a));
    do_fetch(a, 1'b1, ins, stalls);
    e_ins = exp_instr_q.pop_front();
    checks++;
    if (stalls !== lat + 2) $display("FAIL midrst_refetch_stall: got %0d want %0d", stalls, lat + 2);
    else passed++;
    checks++;
    if (ins !== e_ins) $display("FAIL midrst_refetch_instr: got %h want %h", ins, e_ins);
    else passed++;
    checks++;
    s_blk = (seen_q.size() > 0) ? seen_q.pop_front() : 6'h3F;
    if (s_blk !== a[9:4]) $display("FAIL midrst_refetch_addr: got %0d want %0d", s_blk, a[9:4]);
    else passed++;
  endtask

  task automatic test_addr_glitch();
    logic [9:0]  a, b;
    logic [9:0]  toggles [3];
    logic [31:0] ins, e_ins;
    int          stalls;
    a          = 10'h128;  // tag 2, index 2, word 2
    b          = 10'h2D8;  // tag 5, index 5
    toggles[0] = 10'h098;
    toggles[1] = b;
    toggles[2] = a;
    lat = 5;
    seen_q.delete();
    exp_instr_q.push_back(exp_word(a));
    @(posedge clk);
    #1 bus.address = a;
    @(posedge clk);
    #1 bus.address = b;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_address !== a[9:4])
        $display("FAIL glitch_mem_address[%0d]: got %0d want %0d", k, bus.mem_address, a[9:4]);
      else passed++;
      checks++;
      if (bus.busywait !== 1'b1) $display("FAIL glitch_busywait[%0d]: got %b want 1", k, bus.busywait);
      else passed++;
      @(posedge clk);
      #1 bus.address = toggles[k];
    end
    stalls = 0;
    @(negedge clk);
    while (bus.busywait && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    ins   = bus.instruction;
    e_ins = exp_instr_q.pop_front();
    checks++;
    if (stalls >= 100) $display("FAIL glitch_timeout: got %0d want <100", stalls);
    else passed++;
    checks++;
    if (ins !== e_ins) $display("FAIL glitch_instr: got %h want %h", ins, e_ins);
    else passed++;
    checks++;
    if (seen_q.size() != 1) $display("FAIL glitch_bursts: got %0d want 1", seen_q.size());
    else passed++;
    seen_q.delete();
    // Original line must be resident, the glitched index must not be
    do_fetch(a, 1'b0, ins, stalls);
    checks++;
    if (stalls !== 0) $display("FAIL glitch_refetch_hit: got %0d want 0", stalls);
    else passed++;
    exp_instr_q.push_back(exp_word(b));
    do_fetch(b, 1'b0, ins, stalls);
    e_ins = exp_instr_q.pop_front();
    checks++;
    if (stalls !== lat + 2) $display("FAIL glitch_other_miss: got %0d want %0d", stalls, lat + 2);
    else passed++;
    checks++;
    if (ins !== e_ins) $display("FAIL glitch_other_instr: got %h want %h", ins, e_ins);
    else passed++;
  endtask

  initial begin
    for (int b = 0; b < 64; b++) begin
      for (int w = 0; w < 4; w++) begin
        mem_blk[b][w*32 +: 32] = {b[7:0], 8'hA5, w[7:0], 8'h3C};
      end
    end
    mem_blk[0]           = {32'h0B000100, 32'h0A000001, 32'h00010001, 32'h00000009};
    mem_blk[63][127:96]  = 32'hDEADBEEF;

    test_reset();
    test_cold_start();
    test_spatial_hits();
    test_conflict();
    test_top_of_memory();
    test_reset_mid_refill();
    test_addr_glitch();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port (PC / INSTRUCTION) and the 1024-byte instruction memory.
- Replaces the zero-wait combinational fetch path.
- Serves hits in the same cycle.
- On a miss, stalls the CPU with busywait and refills one 16-byte block from a multi-cycle instruction memory.

Parameters:
- NUM_BLOCKS, 8, cache lines; power of two.
- BLOCK_BYTES, 16, bytes per line (4 instruction words).
- ADDR_W, 10, CPU byte-address width (1024-byte space).
- TAG_W, 3, ADDR_W - log2(NUM_BLOCKS) - log2(BLOCK_BYTES).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- address  in  10  CPU PC byte address; bits [1:0] are ignored (word aligned).
- instruction  out  32  fetched word, little-endian within the block.
- busywait  out  1  high means the CPU must hold PC and not advance.
- mem_read  out  1  refill request to instruction memory.
- mem_address  out  6  block address = address[9:4] of the missing line.
- mem_readdata  in  128  refilled block; byte 0 is in bits [7:0].
- mem_busywait  in  1  high while the memory read is in progress.

Behaviour:
- Address split:
  - tag = address[9:7]
  - index = address[6:4]
  - word = address[3:2]
- Storage per line: valid bit, 3-bit tag, 128-bit data.
- hit = valid[index] && tag_array[index] == tag. This is combinational.
- instruction = data[index] word select: word 0 is bits [31:0], word 3 is bits [127:96].
- instruction is combinational. On a miss it holds the last hit value until refill completes.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE:
    - busywait = !hit.
    - On a miss, latch miss_tag/miss_index and go to MEM_READ on the next edge.
    - On a hit, stay in IDLE; zero stall cycles.
  - MEM_READ:
    - mem_read = 1, mem_address = {miss_tag, miss_index}, busywait = 1.
    - Stay while mem_busywait = 1.
    - When mem_busywait = 0 at an edge, capture mem_readdata and go to UPDATE.
  - UPDATE:
    - mem_read = 0, busywait = 1.
    - Write data, tag and valid=1 into line miss_index on the edge.
    - Return to IDLE; the next cycle is a hit and busywait falls.
- Miss penalty = memory latency + 2 cycles (detect/request + update).
- mem_read deasserts in the same cycle the FSM leaves MEM_READ; there are no back-to-back requests without an UPDATE between them.
- The CPU must hold address stable while busywait = 1. The cache uses the latched miss_tag/miss_index regardless, so a glitching address cannot corrupt the refill target.
- Reset (RESET = 0, any state, including mid-refill):
  - All valid bits clear, state goes to IDLE, mem_read = 0.
  - Tag/data arrays are not cleared.
  - A refill in flight is abandoned; the memory response is ignored.
  - While RESET = 0, busywait is forced to 0.
  - The first fetch after reset release always misses.
- Conflict misses (same index, different tag) evict unconditionally. There is no write-back because lines are never dirty.
- Top of address space: 0x3FC maps to tag 7, index 7, word 3. No wrap or overflow handling is needed inside the cache.
- mem_readdata and mem_busywait are sampled only in MEM_READ; they are don't-care in other states.

Decomposition:
- Shared package icache_pkg holds:
  - FSM state encoding (IDLE = 2'd0, MEM_READ = 2'd1, UPDATE = 2'd2).
  - Field-position constants (TAG_LSB = 7, INDEX_LSB = 4, WORD_LSB = 2).
- One natural sub-module, icache_line_array: valid/tag/data storage with async clear of valid, one write port, and one combinational read port returning {valid, tag, data}.
- The FSM and hit logic stay in the top module.

Test Plan:
- Cold start: release RESET, address = 0x000, memory latency 5 cycles, block 0 = words 0x00000009, 0x00010001, 0x0A000001, 0x0B000100.
  - Required: busywait high for 7 cycles, mem_address = 6'd0.
  - Then instruction = 0x00000009 with busywait low.
- Spatial hits: after the cold start, step address 0x004, 0x008, 0x00C one per cycle.
  - Required: busywait stays 0; instruction = 0x00010001, 0x0A000001, 0x0B000100.
  - mem_read never asserts.
- Conflict eviction: fetch 0x010 (index 1, tag 0), then 0x090 (index 1, tag 1), then 0x010 again.
  - Required: three separate misses, each with one mem_read burst; mem_address = 1, 9, 1.
- Top of memory: fetch 0x3FC with block 63 word 3 = 0xDEADBEEF.
  - Required: mem_address = 6'd63; instruction = 0xDEADBEEF after refill.
- Reset mid-refill: drop RESET during cycle 2 of MEM_READ.
  - Required: mem_read = 0 and busywait = 0 immediately (asynchronous).
  - After release, re-fetching the same address misses again and refills correctly.
- Address change during stall: while busywait = 1, toggle address bits [9:4].
  - Required: mem_address stays at the latched block.
  - The line written is the original miss_index.
